// File: rtl/iomem_arbiter_pkg.sv
// Shared types and default constants for the two-master I/O memory arbiter.
package iomem_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [31:0] DEF_ERR_RDATA       = 32'hDEAD_BEEF;
   localparam int          DEF_TIMEOUT_CYCLES  = 255;

endpackage

// File: rtl/iomem_arbiter_timer.sv
// Data-phase watchdog: clear/enable counter with a terminal-count flag.
module iomem_arbiter_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [15:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (en && !term)
         count <= count + 16'd1;
   end

   assign term = (count == 16'(LIMIT - 1));

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one slave port between two masters.
// Optional data-phase timeout enabled by IOMEM_ARBITER_TIMEOUT_EN.
module iomem_arbiter
   import iomem_arbiter_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  m_valid,
   output logic [1:0]  m_ready,
   input  logic [7:0]  m_wstrb,
   input  logic [63:0] m_addr,
   input  logic [63:0] m_wdata,
   output logic [63:0] m_rdata,
   output logic        s_valid,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout
);

   state_t state;
   logic   last;
   logic   gidx, gvalid, term, done, pick1;

   assign gidx   = grant[1];
   assign gvalid = (state == BUSY) && m_valid[gidx];

`ifdef IOMEM_ARBITER_TIMEOUT_EN
   iomem_arbiter_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (state == IDLE),
      .en    (state == BUSY),
      .term  (term)
   );
`else
   assign term = 1'b0;
`endif

   // s_valid drops on the terminal cycle without looking at s_ready,
   // so a slave deriving s_ready from s_valid cannot form a loop.
   assign s_valid = gvalid && !term;
   assign done    = gvalid && (s_ready || term);
   assign timeout = gvalid && term && !s_ready;
   assign m_ready = done ? grant : 2'b00;
   assign m_rdata = {2{timeout ? ERR_RDATA : s_rdata}};

   assign s_wstrb = gidx ? m_wstrb[7:4]   : m_wstrb[3:0];
   assign s_addr  = gidx ? m_addr[63:32]  : m_addr[31:0];
   assign s_wdata = gidx ? m_wdata[63:32] : m_wdata[31:0];

   // Master 1 wins alone, or on a tie when master 0 was served last.
   assign pick1 = m_valid[1] && (!m_valid[0] || !last);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= 2'b00;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (|m_valid) begin
                  grant <= pick1 ? 2'b10 : 2'b01;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (!gvalid) begin
                  grant <= 2'b00;
                  state <= IDLE;
               end else if (done) begin
                  grant <= 2'b00;
                  last  <= gidx;
                  state <= IDLE;
               end
            end
            default: begin
               grant <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter; timeout checks follow IOMEM_ARBITER_TIMEOUT_EN.
module tb_iomem_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  m_valid;
   logic [1:0]  m_ready;
   logic [7:0]  m_wstrb;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic        s_valid, s_ready, timeout;
   logic [3:0]  s_wstrb;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  grant;

   typedef struct {
      int          m;
      logic [31:0] rd;
      logic        to;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   iomem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset),
      .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completion pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (m_ready != 2'b00) begin
         if (q.size() == 0) begin
            chk("unexpected_ready", {62'd0, m_ready}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("ready_master", {62'd0, m_ready}, 64'(2'b01 << e.m));
            chk("rdata", m_rdata, {e.rd, e.rd});
            chk("timeout_flag", {63'd0, timeout}, {63'd0, e.to});
         end
      end else if (timeout) begin
         chk("timeout_without_ready", 64'd1, 64'd0);
      end
   end

   task automatic serve(input int mi, input int lat, input logic [31:0] rd);
      int n = 0;
      logic [1:0] rdy;
      while (!s_valid && n < 50) begin tick(); n++; end
      chk("serve_wait", 64'(n < 50), 64'd1);
      chk("grant", {62'd0, grant}, 64'(2'b01 << mi));
      chk("s_addr", {32'd0, s_addr}, {32'd0, m_addr[32*mi +: 32]});
      chk("s_wstrb", {60'd0, s_wstrb}, {60'd0, m_wstrb[4*mi +: 4]});
      chk("s_wdata", {32'd0, s_wdata}, {32'd0, m_wdata[32*mi +: 32]});
      q.push_back('{mi, rd, 1'b0});
      repeat (lat) tick();
      s_ready = 1'b1;
      s_rdata = rd;
      #1;
      rdy = m_ready;
      tick();
      s_ready = 1'b0;
      m_valid = m_valid & ~rdy;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_grant"}, {62'd0, grant}, 64'd0);
      chk({tag, "_m_ready"}, {62'd0, m_ready}, 64'd0);
      chk({tag, "_s_valid"}, {63'd0, s_valid}, 64'd0);
      chk({tag, "_timeout"}, {63'd0, timeout}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      reset = 1'b1; m_valid = 2'b00; m_wstrb = '0; m_addr = '0; m_wdata = '0;
      s_ready = 1'b0; s_rdata = '0;
      repeat (2) tick();
      check_reset_outputs("reset");
      reset = 1'b0;

      // Single read from master 0, slave answers two cycles after s_valid.
      m_addr[31:0] = 32'h0300_0000;
      m_valid = 2'b01;
      serve(0, 2, 32'h1234_5678);
      chk("grant_after_read", {62'd0, grant}, 64'd0);

      // Simultaneous requests straight after reset alternate 0,1,0,1.
      reset = 1'b1; tick(); reset = 1'b0;
      m_addr = {32'h0000_2000, 32'h0000_1000};
      m_valid = 2'b11;
      serve(0, 0, 32'h0000_00A0);
      serve(1, 1, 32'h0000_00A1);
      m_valid = 2'b11;
      serve(0, 0, 32'h0000_00B0);
      serve(1, 0, 32'h0000_00B1);

      // Write from master 1; master 0 requests mid-transfer and must wait.
      m_wstrb = {4'b0011, 4'b0000};
      m_wdata = {32'hAABB_CCDD, 32'h0};
      m_addr  = {32'h0000_4000, 32'h0000_3000};
      m_valid = 2'b10;
      tick();
      chk("write_grant", {62'd0, grant}, 64'd2);
      m_valid[0] = 1'b1;
      serve(1, 2, 32'h0);
      serve(0, 0, 32'h0000_0055);

      // Abandoned transfer, then s_ready while idle is ignored.
      m_valid = 2'b01;
      tick();
      chk("abandon_grant", {62'd0, grant}, 64'd1);
      m_valid = 2'b00;
      tick();
      chk("abandon_idle", {62'd0, grant}, 64'd0);
      s_ready = 1'b1;
      #1;
      chk("idle_s_ready", {62'd0, m_ready}, 64'd0);
      tick();
      s_ready = 1'b0;
      tick();

      // Slave never answers.
      m_valid = 2'b01;
      tick();
      seen = 0;
`ifdef IOMEM_ARBITER_TIMEOUT_EN
      q.push_back('{0, 32'hDEAD_BEEF, 1'b1});
      for (int k = 1; k <= 50; k++) begin
         if (m_ready != 2'b00) begin
            seen = k;
            chk("timeout_s_valid", {63'd0, s_valid}, 64'd0);
            break;
         end
         tick();
      end
      chk("timeout_cycle", 64'(seen), 64'(TO));
`else
      for (int k = 1; k <= 1000; k++) begin
         if (m_ready != 2'b00) seen++;
         tick();
      end
      chk("no_timeout_ready_count", 64'(seen), 64'd0);
      chk("no_timeout_still_granted", {62'd0, grant}, 64'd1);
`endif
      tick();
      m_valid = 2'b00;
      tick();

`ifdef IOMEM_ARBITER_TIMEOUT_EN
      // s_ready on the terminal cycle completes normally.
      m_valid = 2'b01;
      tick();
      repeat (TO - 1) tick();
      q.push_back('{0, 32'h0000_0077, 1'b0});
      s_ready = 1'b1;
      s_rdata = 32'h0000_0077;
      #1;
      chk("race_timeout", {63'd0, timeout}, 64'd0);
      tick();
      s_ready = 1'b0;
      m_valid = 2'b00;
      tick();
`endif

      // Reset in the second BUSY cycle; held requests restart from master 0.
      m_valid = 2'b01;
      serve(0, 0, 32'h0000_0011);
      m_valid = 2'b01;
      tick();
      m_valid = 2'b11;
      tick();
      chk("busy2_grant", {62'd0, grant}, 64'd1);
      reset = 1'b1;
      tick();
      check_reset_outputs("busy_reset");
      reset = 1'b0;
      tick();
      chk("post_reset_grant", {62'd0, grant}, 64'd1);
      serve(0, 0, 32'h0000_0021);
      serve(1, 0, 32'h0000_0022);

      repeat (3) tick();
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
